// File: rtl/rv32_pkg.sv
// Shared types and constants for the rv32 memory-side blocks.
package rv32_pkg;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_IF,
        RESP_LSU
    } rv32_resp_owner_t;

    localparam int unsigned RV32_ARB_STARVE_DEFAULT = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive refused fetch cycles; boost tells the arbiter to let
// the waiting fetch win over the LSU.
module arb_starve_counter
    import rv32_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = RV32_ARB_STARVE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic if_gnt,
    input  logic if_flush,
    output logic boost
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (if_gnt || !if_req || if_flush) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign boost = (cnt == LIMIT);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one synchronous memory between instruction fetch and the LSU,
// issuing at most one access per cycle and routing read data to its owner.
module imem_dmem_arbiter
    import rv32_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = RV32_ARB_STARVE_DEFAULT,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_gnt,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-3:0] mem_read_addr,
    output logic [ADDR_W-3:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    rv32_resp_owner_t state, state_next;
    logic             boost;
    logic             unused_byte_offset;

    assign unused_byte_offset = ^{if_addr[1:0], lsu_addr[1:0]};

    arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .if_req  (if_req),
        .if_gnt  (if_gnt),
        .if_flush(if_flush),
        .boost   (boost)
    );

    // Flush outranks boost so a redirect never issues a stale fetch.
    always_comb begin
        if_gnt  = 1'b0;
        lsu_gnt = 1'b0;
        if (!reset) begin
            if (if_flush) begin
                lsu_gnt = lsu_req;
            end else if (boost && if_req) begin
                if_gnt = 1'b1;
            end else if (lsu_req) begin
                lsu_gnt = 1'b1;
            end else begin
                if_gnt = if_req;
            end
        end
    end

    always_comb begin
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_read_addr    = '0;
        mem_write_addr   = '0;
        mem_write_data   = '0;
        if (if_gnt) begin
            mem_read_enable = 1'b1;
            mem_read_addr   = if_addr[ADDR_W-1:2];
        end else if (lsu_gnt && !lsu_we) begin
            mem_read_enable = 1'b1;
            mem_read_addr   = lsu_addr[ADDR_W-1:2];
        end else if (lsu_gnt && lsu_we) begin
            mem_write_enable = 1'b1;
            mem_write_addr   = lsu_addr[ADDR_W-1:2];
            mem_write_data   = lsu_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RESP_NONE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = RESP_NONE;
        if (if_gnt) begin
            state_next = RESP_IF;
        end else if (lsu_gnt && !lsu_we) begin
            state_next = RESP_LSU;
        end
    end

    always_comb begin
        if_rvalid  = 1'b0;
        lsu_rvalid = 1'b0;
        case (state)
            RESP_IF:  if_rvalid  = !if_flush;
            RESP_LSU: lsu_rvalid = 1'b1;
            default:  ;
        endcase
    end

    assign if_rdata  = mem_read_data;
    assign lsu_rdata = mem_read_data;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with a behavioural synchronous memory
// and a scoreboard of expected response owner and data per cycle.
module tb_imem_dmem_arbiter;
    import rv32_pkg::*;

    typedef struct {
        rv32_resp_owner_t owner;
        logic [31:0]      data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        mem_read_enable, mem_write_enable;
    logic [29:0] mem_read_addr, mem_write_addr;
    logic [31:0] mem_write_data, mem_read_data;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    imem_dmem_arbiter #(
        .STARVE_LIMIT(4),
        .ADDR_W      (32),
        .DATA_W      (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_flush        (if_flush),
        .if_gnt          (if_gnt),
        .if_rvalid       (if_rvalid),
        .if_rdata        (if_rdata),
        .lsu_req         (lsu_req),
        .lsu_we          (lsu_we),
        .lsu_addr        (lsu_addr),
        .lsu_wdata       (lsu_wdata),
        .lsu_gnt         (lsu_gnt),
        .lsu_rvalid      (lsu_rvalid),
        .lsu_rdata       (lsu_rdata),
        .mem_read_enable (mem_read_enable),
        .mem_write_enable(mem_write_enable),
        .mem_read_addr   (mem_read_addr),
        .mem_write_addr  (mem_write_addr),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data)
    );

    // Synchronous memory: read data appears the cycle after read_enable.
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_write_addr[9:0]] <= mem_write_data;
        if (mem_read_enable)  mem_read_data <= mem[mem_read_addr[9:0]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check grants/issue and the response due
    // this cycle, then queue the response expected next cycle.
    task automatic cyc(input logic r, input logic ir, input logic [31:0] ia, input logic fl,
                       input logic lr, input logic lw, input logic [31:0] la,
                       input logic [31:0] ld, input logic eig, input logic elg);
        exp_t        e;
        exp_t        n;
        logic        exp_re, exp_we;
        logic [29:0] exp_ra, exp_wa;
        logic [31:0] exp_wd;
        reset = r; if_req = ir; if_addr = ia; if_flush = fl;
        lsu_req = lr; lsu_we = lw; lsu_addr = la; lsu_wdata = ld;
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
            e.owner = RESP_NONE;
            e.data  = '0;
        end else begin
            e = sb.pop_front();
        end
        if (r) e.owner = RESP_NONE;
        exp_re = eig || (elg && !lw);
        exp_we = elg && lw;
        exp_ra = eig ? ia[31:2] : ((elg && !lw) ? la[31:2] : 30'd0);
        exp_wa = exp_we ? la[31:2] : 30'd0;
        exp_wd = exp_we ? ld : 32'd0;
        chk("if_gnt", 64'(if_gnt), 64'(eig));
        chk("lsu_gnt", 64'(lsu_gnt), 64'(elg));
        chk("mem_read_enable", 64'(mem_read_enable), 64'(exp_re));
        chk("mem_write_enable", 64'(mem_write_enable), 64'(exp_we));
        chk("mem_read_addr", 64'(mem_read_addr), 64'(exp_ra));
        chk("mem_write_addr", 64'(mem_write_addr), 64'(exp_wa));
        chk("mem_write_data", 64'(mem_write_data), 64'(exp_wd));
        chk("if_rvalid", 64'(if_rvalid), 64'(e.owner == RESP_IF && !fl));
        chk("lsu_rvalid", 64'(lsu_rvalid), 64'(e.owner == RESP_LSU));
        if (e.owner == RESP_IF && !fl) chk("if_rdata", 64'(if_rdata), 64'(e.data));
        if (e.owner == RESP_LSU) chk("lsu_rdata", 64'(lsu_rdata), 64'(e.data));
        n.data = eig ? ref_mem[ia[11:2]] : ref_mem[la[11:2]];
        if (eig) n.owner = RESP_IF;
        else if (elg && !lw) n.owner = RESP_LSU;
        else n.owner = RESP_NONE;
        if (exp_we) ref_mem[la[11:2]] = ld;
        sb.push_back(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t first;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'(i) * 32'h9E37_79B1 + 32'h0000_0007;
            ref_mem[i] = 32'(i) * 32'h9E37_79B1 + 32'h0000_0007;
        end
        first.owner = RESP_NONE;
        first.data  = '0;
        sb.push_back(first);

        // Reset with both requesters active: grants must stay low.
        cyc(1, 1, 32'h0, 0, 1, 0, 32'h100, 0, 0, 0);
        cyc(1, 1, 32'h0, 0, 1, 0, 32'h100, 0, 0, 0);

        // Fetch-only stream, then an idle cycle to collect the last response.
        cyc(0, 1, 32'h0, 0, 0, 0, 32'h0, 0, 1, 0);
        cyc(0, 1, 32'h4, 0, 0, 0, 32'h0, 0, 1, 0);
        cyc(0, 1, 32'h8, 0, 0, 0, 32'h0, 0, 1, 0);
        cyc(0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0);

        // Collision: LSU load wins, fetch follows once LSU is quiet.
        cyc(0, 1, 32'h10, 0, 1, 0, 32'h100, 0, 0, 1);
        cyc(0, 1, 32'h10, 0, 0, 0, 32'h0, 0, 1, 0);

        // Starvation: fetch forced through on the 5th and 10th cycles.
        for (int i = 0; i < 10; i++)
            cyc(0, 1, 32'h40, 0, 1, 0, 32'h200 + 32'(4 * i), 0, (i == 4 || i == 9), !(i == 4 || i == 9));

        // Flush kills the in-flight fetch response.
        cyc(0, 1, 32'h80, 0, 0, 0, 32'h0, 0, 1, 0);
        cyc(0, 1, 32'h84, 1, 0, 0, 32'h0, 0, 0, 0);
        // Build starvation to 3, flush must clear it.
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 32'h84, 0, 1, 0, 32'h300 + 32'(4 * i), 0, 0, 1);
        cyc(0, 1, 32'h84, 1, 1, 0, 32'h310, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            cyc(0, 1, 32'h84, 0, 1, 0, 32'h320 + 32'(4 * i), 0, 0, 1);
        cyc(0, 1, 32'h84, 0, 1, 0, 32'h330, 0, 1, 0);
        cyc(0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0);

        // Store then load-back through a misaligned byte address.
        cyc(0, 0, 32'h0, 0, 1, 1, 32'h20, 32'hDEAD_BEEF, 0, 1);
        cyc(0, 0, 32'h0, 0, 1, 0, 32'h22, 0, 0, 1);
        cyc(0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0);

        // Reset right after a load grant drops its response.
        cyc(0, 0, 32'h0, 0, 1, 0, 32'h100, 0, 0, 1);
        cyc(1, 1, 32'h0, 0, 1, 0, 32'h100, 0, 0, 0);
        cyc(1, 1, 32'h0, 0, 1, 0, 32'h100, 0, 0, 0);
        cyc(0, 1, 32'h0, 0, 0, 0, 32'h0, 0, 1, 0);
        cyc(0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0);
        cyc(0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares the single `mem` instance between two requesters: the instruction-fetch path and the load/store unit (LSU).
- At most one access is issued per cycle.
- Read responses return one cycle after issue and are routed back to the requester that owns them.
- LSU has priority over fetch. A starvation counter forces a fetch grant when fetch has waited too long.
- A fetch flush from branch redirect kills the in-flight fetch response.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles an IF request may be refused before IF wins priority. Legal range 1..15.
- ADDR_W, 32: byte address width of requester ports.
- DATA_W, 32: data width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until granted
- if_addr  in  ADDR_W  fetch byte address
- if_flush  in  1  branch redirect; kills current and in-flight fetch
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- lsu_req  in  1  LSU request; held until granted
- lsu_we  in  1  1 = store, 0 = load
- lsu_addr  in  ADDR_W  LSU byte address
- lsu_wdata  in  DATA_W  store data
- lsu_gnt  out  1  LSU request accepted this cycle
- lsu_rvalid  out  1  load data valid
- lsu_rdata  out  DATA_W  load data
- mem_read_enable  out  1  to mem read_enable
- mem_write_enable  out  1  to mem write_enable
- mem_read_addr  out  ADDR_W-2  word address, [ADDR_W-1:2]
- mem_write_addr  out  ADDR_W-2  word address
- mem_write_data  out  DATA_W  store data
- mem_read_data  in  DATA_W  mem output, valid the cycle after read_enable

Behaviour:
- Grant logic is combinational. Both grants are forced to 0 while reset is high.
- Grant rules, evaluated in order:
  - If if_flush=1: if_gnt=0; lsu_gnt=lsu_req.
  - Else if boost (starve_cnt==STARVE_LIMIT) and if_req: if_gnt=1, lsu_gnt=0.
  - Else if lsu_req: lsu_gnt=1, if_gnt=0.
  - Else: if_gnt=if_req.
- Never assert both grants in the same cycle.
- Issue on grant:
  - Fetch: mem_read_enable=1, mem_read_addr=if_addr[ADDR_W-1:2].
  - LSU load: mem_read_enable=1, mem_read_addr=lsu_addr[ADDR_W-1:2].
  - LSU store: mem_write_enable=1, mem_write_addr=lsu_addr[ADDR_W-1:2], mem_write_data=lsu_wdata; no response.
  - No grant: both enables 0. Address and data outputs are don't-care; drive 0.
- Byte offset bits [1:0] are ignored; there is no misalignment check.
- starve_cnt:
  - Registered, 4 bits. Reset value 0.
  - Increments, saturating at STARVE_LIMIT, when if_req && !if_gnt && !if_flush.
  - Clears to 0 when if_gnt=1, when if_req=0, or when if_flush=1.
- Response-owner FSM (registered), states RESP_NONE, RESP_IF, RESP_LSU. Reset state RESP_NONE.
  - Next state = RESP_IF if a fetch was granted this cycle.
  - Next state = RESP_LSU if an LSU load was granted this cycle.
  - Otherwise next state = RESP_NONE; a store is treated as no read.
- Back-to-back grants every cycle are allowed; the FSM updates every cycle with no bubble.
- if_rvalid = (state==RESP_IF) && !if_flush. This means a flush in the response cycle drops the data.
- lsu_rvalid = (state==RESP_LSU).
- if_rdata and lsu_rdata are both wired to mem_read_data, qualified only by their rvalid.
- Reset:
  - All rvalid = 0, enables = 0, grants = 0, state = RESP_NONE, starve_cnt = 0.
  - Reset mid-transaction drops any in-flight response; no rvalid appears after reset deasserts.
- Latency: read grant in cycle N gives rvalid in cycle N+1. Store completes in the grant cycle.

Decomposition:
- rv32_pkg gains:
  - enum rv32_resp_owner_t {RESP_NONE, RESP_IF, RESP_LSU}.
  - Constant RV32_ARB_STARVE_DEFAULT = 4.
- One natural sub-module: arb_starve_counter, holding the saturating counter and the boost flag.
- The mem instance stays outside this block. The arbiter only drives mem's ports.

Test Plan:
- Fetch only: if_req=1, addr 0x0, 0x4, 0x8 on consecutive cycles with lsu_req=0 → if_gnt=1 every cycle; mem_read_addr=0,1,2; if_rvalid=1 in cycles N+1..N+3 with matching mem data.
- Collision: if_req=1 and lsu_req=1 (load at 0x100) in the same cycle → lsu_gnt=1, if_gnt=0, mem_read_addr=0x40; next cycle lsu_rvalid=1, if_rvalid=0.
- Starvation: lsu_req held at 1 for 10 cycles with if_req=1 and STARVE_LIMIT=4 → IF refused 4 cycles, granted in cycle 5, starve_cnt back to 0, LSU resumes in cycle 6.
- Flush: fetch granted in cycle N, if_flush=1 in cycle N+1 → if_rvalid=0 in N+1, if_gnt=0 in N+1, starve_cnt=0.
- Store: lsu_we=1, lsu_addr=0x20, lsu_wdata=0xDEADBEEF → mem_write_enable=1, mem_write_addr=0x8, no lsu_rvalid; a following load of 0x20 returns 0xDEADBEEF.
- Reset mid-operation: assert reset in the cycle after a load grant → lsu_rvalid=0 immediately; all outputs stay 0 until reset deasserts; the first post-reset fetch of 0x0 behaves normally.
